// File: rtl/cbsc_pkg.sv
// cbsc_pkg: state encoding and default counter width shared by the weight-window blocks
package cbsc_pkg;
  localparam int CW_DEF = 8;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
endpackage

// File: rtl/up_counter.sv
// up_counter: CW-bit counter with clear, enable and sticky overflow; saturates when CNT_SAT_EN is defined
module up_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  logic carry;
  assign carry = en & (&cnt);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en) begin
`ifdef CNT_SAT_EN
      cnt <= carry ? cnt : cnt + 1'b1;
`else
      cnt <= cnt + 1'b1;
`endif
      ovf <= ovf | carry;
    end
  end
endmodule

// File: rtl/ones_cnt_capture.sv
// ones_cnt_capture: counts stream ones and window length between start and stop, returns them over valid/ready.
// Build option CNT_SAT_EN makes the counters saturate instead of wrap.
module ones_cnt_capture
  import cbsc_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_in,
  input  logic          stop,
  output logic [CW-1:0] ones,
  output logic [CW-1:0] len,
  output logic          ovf,
  output logic          busy,
  output logic          valid,
  input  logic          ready
);
  state_t state, next;
  logic clr, cnt_en, ones_ovf, len_ovf;
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  // a handshake with start asserted reopens the window without passing through IDLE
  always_comb begin
    next = (state == IDLE)  ? (start ? COUNT : IDLE) :
           (state == COUNT) ? (stop ? DONE : COUNT) :
           (ready ? (start ? COUNT : IDLE) : DONE);
    clr  = start && (state == IDLE || (state == DONE && ready));
  end
  assign busy   = (state == COUNT);
  assign valid  = (state == DONE);
  assign cnt_en = busy & ~stop;
  assign ovf    = ones_ovf | len_ovf;
  up_counter #(.CW(CW)) u_ones (
    .clk(clk), .rst(rst), .clr(clr), .en(cnt_en & bit_in), .cnt(ones), .ovf(ones_ovf)
  );
  up_counter #(.CW(CW)) u_len (
    .clk(clk), .rst(rst), .clr(clr), .en(cnt_en), .cnt(len), .ovf(len_ovf)
  );
endmodule

// File: tb/tb_ones_cnt_capture.sv
// tb_ones_cnt_capture: scoreboard bench driving an 8-bit and a 4-bit instance with the same directed windows
module tb_ones_cnt_capture;
  logic clk = 0, rst = 1, start = 0, bit_in = 0, stop = 0, ready = 0;
  logic [7:0] ones8, len8;
  logic [3:0] ones4, len4;
  logic ovf8, busy8, valid8, ovf4, busy4, valid4;
  int vectors = 0, errors = 0;
  typedef struct packed {logic [7:0] ones; logic [7:0] len; logic ovf;} exp_t;
  exp_t q8[$], q4[$];

  always #5 clk = ~clk;

  ones_cnt_capture #(.CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .stop(stop),
    .ones(ones8), .len(len8), .ovf(ovf8), .busy(busy8), .valid(valid8), .ready(ready)
  );
  ones_cnt_capture #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .stop(stop),
    .ones(ones4), .len(len4), .ovf(ovf4), .busy(busy4), .valid(valid4), .ready(ready)
  );

  function automatic exp_t mk(input int o, input int l, input bit v);
    mk.ones = 8'(o);
    mk.len  = 8'(l);
    mk.ovf  = v;
  endfunction

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // monitor: compares whenever a result is presented, pops on handshake
  initial forever begin
    @(negedge clk);
    #3;
    if (valid8) begin
      if (q8.size() == 0) cmp("valid8_unexpected", 8'(valid8), 8'd0);
      else begin
        cmp("ones8", ones8, q8[0].ones);
        cmp("len8", len8, q8[0].len);
        cmp("ovf8", 8'(ovf8), 8'(q8[0].ovf));
        if (ready) void'(q8.pop_front());
      end
    end
    if (valid4) begin
      if (q4.size() == 0) cmp("valid4_unexpected", 8'(valid4), 8'd0);
      else begin
        cmp("ones4", 8'(ones4), q4[0].ones);
        cmp("len4", 8'(len4), q4[0].len);
        cmp("ovf4", 8'(ovf4), 8'(q4[0].ovf));
        if (ready) void'(q4.pop_front());
      end
    end
  end

  task automatic begin_window();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic feed(input int n, input logic [31:0] bits);
    for (int i = 0; i < n; i++) begin
      bit_in = bits[i];
      tick();
    end
    bit_in = 0;
  endtask

  // the bit presented with stop is 1 so that its exclusion is exercised
  task automatic end_window(input exp_t e8, input exp_t e4);
    q8.push_back(e8);
    q4.push_back(e4);
    stop = 1;
    bit_in = 1;
    tick();
    stop = 0;
    bit_in = 0;
    cmp("latency8", 8'(valid8), 8'd1);
    cmp("latency4", 8'(valid4), 8'd1);
  endtask

  task automatic accept(input int hold, input bit chain);
    for (int i = 0; i < hold; i++) tick();
    ready = 1;
    start = chain;
    tick();
    ready = 0;
    start = 0;
    cmp("valid_drop", 8'(valid8), 8'd0);
    cmp("b2b_busy8", 8'(busy8), 8'(chain));
    cmp("b2b_busy4", 8'(busy4), 8'(chain));
  endtask

  task automatic check_idle(input string nm);
    cmp({nm, "_ones8"}, ones8, 8'd0);
    cmp({nm, "_len8"}, len8, 8'd0);
    cmp({nm, "_ovf8"}, 8'(ovf8), 8'd0);
    cmp({nm, "_busy8"}, 8'(busy8), 8'd0);
    cmp({nm, "_valid8"}, 8'(valid8), 8'd0);
    cmp({nm, "_ones4"}, 8'(ones4), 8'd0);
    cmp({nm, "_busy4"}, 8'(busy4), 8'd0);
    cmp({nm, "_valid4"}, 8'(valid4), 8'd0);
  endtask

  initial begin
    tick();
    tick();
    check_idle("reset");
    rst = 0;
    tick();
    check_idle("idle");
    // 1: five ones
    begin_window();
    feed(5, 32'h1F);
    end_window(mk(5, 5, 0), mk(5, 5, 0));
    accept(0, 0);
    // 2: alternating 1,0 for eight cycles
    begin_window();
    feed(8, 32'h55);
    end_window(mk(4, 8, 0), mk(4, 8, 0));
    accept(1, 0);
    // 3: zero-weight window
    begin_window();
    end_window(mk(0, 0, 0), mk(0, 0, 0));
    accept(0, 0);
    // 4: backpressure then back-to-back window
    begin_window();
    feed(3, 32'h5);
    end_window(mk(2, 3, 0), mk(2, 3, 0));
    accept(3, 1);
    feed(2, 32'h3);
    end_window(mk(2, 2, 0), mk(2, 2, 0));
    accept(0, 0);
    // 5: sixteen ones overflow the 4-bit instance only
    begin_window();
    feed(16, 32'hFFFF);
`ifdef CNT_SAT_EN
    end_window(mk(16, 16, 0), mk(15, 15, 1));
`else
    end_window(mk(16, 16, 0), mk(0, 0, 1));
`endif
    accept(0, 0);
    // 6: reset aborts a window
    begin_window();
    feed(3, 32'h7);
    rst = 1;
    tick();
    rst = 0;
    check_idle("abort");
    for (int i = 0; i < 4; i++) tick();
    check_idle("abort_after");
    cmp("pending8", 8'(q8.size()), 8'd0);
    cmp("pending4", 8'(q4.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
